// File: rtl/rf_cmd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rf_cmd_ctrl_pkg
//    Shared system-control definitions for the register-file command
//    controller: command opcodes received over the RX byte stream, the
//    controller state encoding and the response watchdog limit.
// ---------------------------------------------------------------------------
package rf_cmd_ctrl_pkg;

   // Command opcodes (first byte of every frame)
   localparam logic [7:0] OPC_RF_WR     = 8'hAA;
   localparam logic [7:0] OPC_RF_RD     = 8'hBB;
   localparam logic [7:0] OPC_ALU_OP    = 8'hCC;
   localparam logic [7:0] OPC_ALU_NO_OP = 8'hDD;

   // Number of cycles a wait state tolerates without its valid strobe
   localparam logic [2:0] WDOG_LIMIT = 3'd7;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WR_ADDR  = 4'd1,
      WR_DATA  = 4'd2,
      RD_ADDR  = 4'd3,
      RD_WAIT  = 4'd4,
      OP_A     = 4'd5,
      OP_B     = 4'd6,
      ALU_FN   = 4'd7,
      ALU_WAIT = 4'd8,
      TX_B0    = 4'd9,
      TX_B1    = 4'd10
   } state_t;

endpackage

// File: rtl/rf_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// rf_cmd_ctrl
//    Decodes command frames arriving as RX bytes and drives the register
//    file, the ALU and the TX FIFO accordingly.
//       AA addr data      : register write
//       BB addr           : register read, result byte sent to TX
//       CC a b fn         : write operands to regs 0/1, run ALU, send 2 bytes
//       DD fn             : run ALU on existing operands, send 2 bytes
//
// Ports
//    CLK           system clock, rising edge
//    RST           synchronous active-low reset
//    RX_P_DATA     received byte, qualified by RX_D_VLD
//    RdData        register file read data, qualified by RdData_Valid
//    ALU_OUT       ALU result, qualified by OUT_VALID
//    FIFO_FULL     TX FIFO full, stalls TX pushes
//    Address, WrEn, RdEn, WrData   register file access
//    ALU_EN, ALU_FUN, CLK_EN       ALU start strobe, function, clock gate
//    TX_P_DATA, TX_D_VLD           TX FIFO push
// ---------------------------------------------------------------------------
module rf_cmd_ctrl
   import rf_cmd_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
   input  logic                      RX_D_VLD,
   input  logic [DATA_WIDTH-1:0]     RdData,
   input  logic                      RdData_Valid,
   input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
   input  logic                      OUT_VALID,
   input  logic                      FIFO_FULL,
   output logic [ADDR_WIDTH-1:0]     Address,
   output logic                      WrEn,
   output logic                      RdEn,
   output logic [DATA_WIDTH-1:0]     WrData,
   output logic                      ALU_EN,
   output logic [3:0]                ALU_FUN,
   output logic                      CLK_EN,
   output logic [DATA_WIDTH-1:0]     TX_P_DATA,
   output logic                      TX_D_VLD
);

   state_t                    state_q, state_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [2*DATA_WIDTH-1:0]   hold_q, hold_d;
   logic                      one_byte_q, one_byte_d;
   logic [2:0]                wdog_q, wdog_d;

   // State and context registers, cleared by the synchronous reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         hold_q     <= '0;
         one_byte_q <= 1'b0;
         wdog_q     <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         hold_q     <= hold_d;
         one_byte_q <= one_byte_d;
         wdog_q     <= wdog_d;
      end
   end

   // Next-state and Mealy strobe logic. Strobes are issued in the same cycle
   // as the qualifying input strobe; every output is forced low in reset so
   // a frame interrupted by reset never leaks a strobe.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      hold_d     = hold_q;
      one_byte_d = one_byte_q;
      wdog_d     = wdog_q;

      Address    = '0;
      WrEn       = 1'b0;
      RdEn       = 1'b0;
      WrData     = '0;
      ALU_EN     = 1'b0;
      ALU_FUN    = 4'd0;
      CLK_EN     = 1'b0;
      TX_P_DATA  = '0;
      TX_D_VLD   = 1'b0;

      case (state_q)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == DATA_WIDTH'(OPC_RF_WR))
                  state_d = WR_ADDR;
               else if (RX_P_DATA == DATA_WIDTH'(OPC_RF_RD))
                  state_d = RD_ADDR;
               else if (RX_P_DATA == DATA_WIDTH'(OPC_ALU_OP))
                  state_d = OP_A;
               else if (RX_P_DATA == DATA_WIDTH'(OPC_ALU_NO_OP))
                  state_d = ALU_FN;
            end
         end

         WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
               state_d = WR_DATA;
            end
         end

         WR_DATA: begin
            if (RX_D_VLD) begin
               WrEn    = 1'b1;
               Address = addr_q;
               WrData  = RX_P_DATA;
               state_d = IDLE;
            end
         end

         RD_ADDR: begin
            if (RX_D_VLD) begin
               RdEn    = 1'b1;
               Address = RX_P_DATA[ADDR_WIDTH-1:0];
               wdog_d  = '0;
               state_d = RD_WAIT;
            end
         end

         // The strobe wins over the watchdog, so a response in the last
         // tolerated cycle is still taken.
         RD_WAIT: begin
            if (RdData_Valid) begin
               hold_d     = {{DATA_WIDTH{1'b0}}, RdData};
               one_byte_d = 1'b1;
               state_d    = TX_B0;
            end else if (wdog_q == WDOG_LIMIT - 3'd1) begin
               state_d = IDLE;
            end else begin
               wdog_d = wdog_q + 3'd1;
            end
         end

         OP_A: begin
            if (RX_D_VLD) begin
               WrEn    = 1'b1;
               Address = '0;
               WrData  = RX_P_DATA;
               state_d = OP_B;
            end
         end

         OP_B: begin
            if (RX_D_VLD) begin
               WrEn    = 1'b1;
               Address = ADDR_WIDTH'(1);
               WrData  = RX_P_DATA;
               state_d = ALU_FN;
            end
         end

         // Clock gate opens while waiting for the function byte so the ALU
         // is already clocked when ALU_EN fires.
         ALU_FN: begin
            CLK_EN = 1'b1;
            if (RX_D_VLD) begin
               ALU_EN  = 1'b1;
               ALU_FUN = RX_P_DATA[3:0];
               wdog_d  = '0;
               state_d = ALU_WAIT;
            end
         end

         ALU_WAIT: begin
            CLK_EN = 1'b1;
            if (OUT_VALID) begin
               hold_d     = ALU_OUT;
               one_byte_d = 1'b0;
               state_d    = TX_B0;
            end else if (wdog_q == WDOG_LIMIT - 3'd1) begin
               state_d = IDLE;
            end else begin
               wdog_d = wdog_q + 3'd1;
            end
         end

         TX_B0: begin
            if (!FIFO_FULL) begin
               TX_D_VLD  = 1'b1;
               TX_P_DATA = hold_q[DATA_WIDTH-1:0];
               state_d   = one_byte_q ? IDLE : TX_B1;
            end
         end

         TX_B1: begin
            if (!FIFO_FULL) begin
               TX_D_VLD  = 1'b1;
               TX_P_DATA = hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
               state_d   = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      if (!RST) begin
         Address   = '0;
         WrEn      = 1'b0;
         RdEn      = 1'b0;
         WrData    = '0;
         ALU_EN    = 1'b0;
         ALU_FUN   = 4'd0;
         CLK_EN    = 1'b0;
         TX_P_DATA = '0;
         TX_D_VLD  = 1'b0;
      end
   end

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_cmd_ctrl
//    Self-checking bench for rf_cmd_ctrl: a cycle table for the reference
//    frames, hand-written watchdog/reset sequences, and random frames checked
//    against a transaction-level list of expected strobes.
// ---------------------------------------------------------------------------
module tb_rf_cmd_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic [7:0]  RdData;
   logic        RdData_Valid;
   logic [15:0] ALU_OUT;
   logic        OUT_VALID;
   logic        FIFO_FULL;
   logic [3:0]  Address;
   logic        WrEn;
   logic        RdEn;
   logic [7:0]  WrData;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic        CLK_EN;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;

   rf_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .CLK(CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RdData(RdData), .RdData_Valid(RdData_Valid),
      .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
      .FIFO_FULL(FIFO_FULL),
      .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
      .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        rx_vld;
      logic [7:0]  rx;
      logic        rd_vld;
      logic [7:0]  rd;
      logic        out_vld;
      logic [15:0] alu;
      logic        ff;
   } in_t;

   typedef struct packed {
      logic       we;
      logic       re;
      logic [3:0] addr;
      logic [7:0] wd;
      logic       ae;
      logic [3:0] af;
      logic       ce;
      logic       tv;
      logic [7:0] td;
   } out_t;

   typedef struct {
      in_t  i;
      out_t o;
   } vec_t;

   int checks = 0;
   int errors = 0;

   vec_t        tbl[$];
   logic [23:0] obs_q[$];
   logic [23:0] exp_q[$];

   // Stimulus / expectation builders
   function automatic in_t mk_in(input logic rv, input logic [7:0] rx,
                                 input logic dv, input logic [7:0] rd,
                                 input logic ov, input logic [15:0] alu,
                                 input logic ff);
      in_t v;
      v.rx_vld = rv; v.rx = rx; v.rd_vld = dv; v.rd = rd;
      v.out_vld = ov; v.alu = alu; v.ff = ff;
      return v;
   endfunction

   function automatic in_t idle_in();
      return mk_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
   endfunction

   function automatic in_t rx_in(input logic [7:0] b);
      return mk_in(1'b1, b, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
   endfunction

   function automatic in_t rd_in(input logic [7:0] d);
      return mk_in(1'b0, 8'h00, 1'b1, d, 1'b0, 16'h0000, 1'b0);
   endfunction

   function automatic in_t ov_in(input logic [15:0] r);
      return mk_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, r, 1'b0);
   endfunction

   // FIFO full while a stray command byte arrives
   function automatic in_t ff_in();
      return mk_in(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1);
   endfunction

   function automatic out_t zo();
      return '0;
   endfunction

   function automatic out_t o_we(input logic [3:0] a, input logic [7:0] d);
      out_t o = '0;
      o.we = 1'b1; o.addr = a; o.wd = d;
      return o;
   endfunction

   function automatic out_t o_re(input logic [3:0] a);
      out_t o = '0;
      o.re = 1'b1; o.addr = a;
      return o;
   endfunction

   function automatic out_t o_ae(input logic [3:0] f);
      out_t o = '0;
      o.ae = 1'b1; o.af = f; o.ce = 1'b1;
      return o;
   endfunction

   function automatic out_t o_ce();
      out_t o = '0;
      o.ce = 1'b1;
      return o;
   endfunction

   function automatic out_t o_tx(input logic [7:0] d);
      out_t o = '0;
      o.tv = 1'b1; o.td = d;
      return o;
   endfunction

   function automatic string fmt(input out_t o);
      return $sformatf("we=%0b re=%0b addr=%h wd=%h ae=%0b af=%h ce=%0b tv=%0b td=%h",
                       o.we, o.re, o.addr, o.wd, o.ae, o.af, o.ce, o.tv, o.td);
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [7:0] rand_opc();
      case ($urandom_range(0, 3))
         0:       return 8'hAA;
         1:       return 8'hBB;
         2:       return 8'hCC;
         default: return 8'hDD;
      endcase
   endfunction

   // Expected-event encodings: {kind, addr, data, extra}
   function automatic logic [23:0] ev_w(input logic [3:0] a, input logic [7:0] d);
      return {4'h1, a, d, 8'h00};
   endfunction
   function automatic logic [23:0] ev_r(input logic [3:0] a);
      return {4'h2, a, 8'h00, 8'h00};
   endfunction
   function automatic logic [23:0] ev_a(input logic [3:0] f);
      return {4'h3, 4'h0, 8'h00, 4'h8, f};
   endfunction
   function automatic logic [23:0] ev_t(input logic [7:0] d);
      return {4'h4, 4'h0, d, 8'h00};
   endfunction

   task automatic apply_stimulus(input in_t v);
      RX_D_VLD     = v.rx_vld;
      RX_P_DATA    = v.rx;
      RdData_Valid = v.rd_vld;
      RdData       = v.rd;
      OUT_VALID    = v.out_vld;
      ALU_OUT      = v.alu;
      FIFO_FULL    = v.ff;
   endtask

   task automatic check_output(input string name, input out_t exp);
      out_t act;
      act = {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_D_VLD, TX_P_DATA};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
      end
   endtask

   // One checked cycle: drive at the falling edge, compare 1ns later
   task automatic cyc(input string name, input in_t v, input out_t exp);
      apply_stimulus(v);
      #1;
      check_output(name, exp);
      @(negedge CLK);
   endtask

   // One monitored cycle for random frames: record strobes as events
   task automatic rstep(input in_t v);
      apply_stimulus(v);
      #1;
      if (WrEn)     obs_q.push_back({4'h1, Address, WrData, 8'h00});
      if (RdEn)     obs_q.push_back({4'h2, Address, 8'h00, 8'h00});
      if (ALU_EN)   obs_q.push_back({4'h3, 4'h0, 8'h00, CLK_EN, 3'b000, ALU_FUN});
      if (TX_D_VLD) obs_q.push_back({4'h4, 4'h0, TX_P_DATA, 8'h00});
      checks++;
      if ((!(WrEn || RdEn) && Address !== 4'h0) || (!WrEn && WrData !== 8'h00)) begin
         errors++;
         $display("[TB] FAIL idle_bus: got addr=%h wd=%h with we=%0b re=%0b, required 0 outside strobes",
                  Address, WrData, WrEn, RdEn);
      end
      @(negedge CLK);
   endtask

   task automatic send_byte(input logic [7:0] b);
      repeat ($urandom_range(0, 2))
         rstep(mk_in(1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0, 16'h0000, rbit()));
      rstep(mk_in(1'b1, b, 1'b0, 8'h00, 1'b0, 16'h0000, rbit()));
   endtask

   // Wait k cycles after the request, dropping stray bytes while the block
   // is still waiting, then present the response strobe
   task automatic wait_resp(input int k, input logic is_alu, input logic [15:0] val);
      for (int j = 0; j < k; j++) begin
         logic drop;
         drop = (j < 7) ? rbit() : 1'b0;
         rstep(mk_in(drop, rand_opc(), 1'b0, 8'($urandom), 1'b0, 16'($urandom), rbit()));
      end
      rstep(mk_in(1'b0, 8'h00, !is_alu, val[7:0], is_alu, val, rbit()));
   endtask

   task automatic drain();
      repeat (6) rstep(mk_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, rbit()));
      repeat (10) rstep(idle_in());
   endtask

   task automatic compare_frame(input int n, input int kind);
      int m;
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("[TB] FAIL frame%0d_kind%0d_count: got %0d events, expected %0d",
                  n, kind, obs_q.size(), exp_q.size());
      end
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL frame%0d_kind%0d_ev%0d: got %h expected %h",
                     n, kind, i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      RST = 1'b0;
      apply_stimulus(idle_in());
      @(negedge CLK);

      // Reset: outputs stay low even with every input strobe active
      repeat (2)
         cyc("reset_outputs", mk_in(1'b1, 8'hDD, 1'b1, 8'h55, 1'b1, 16'hFFFF, 1'b0), zo());
      RST = 1'b1;

      // Reference frames, one row per cycle
      tbl.push_back('{rx_in(8'hAA), zo()});
      tbl.push_back('{rx_in(8'h05), zo()});
      tbl.push_back('{rx_in(8'h3C), o_we(4'h5, 8'h3C)});
      tbl.push_back('{idle_in(),    zo()});
      tbl.push_back('{rx_in(8'hBB), zo()});
      tbl.push_back('{rx_in(8'h05), o_re(4'h5)});
      tbl.push_back('{rd_in(8'h3C), zo()});
      tbl.push_back('{idle_in(),    o_tx(8'h3C)});
      tbl.push_back('{idle_in(),    zo()});
      tbl.push_back('{rx_in(8'hCC), zo()});
      tbl.push_back('{rx_in(8'h07), o_we(4'h0, 8'h07)});
      tbl.push_back('{rx_in(8'h03), o_we(4'h1, 8'h03)});
      tbl.push_back('{idle_in(),    o_ce()});
      tbl.push_back('{rx_in(8'h00), o_ae(4'h0)});
      tbl.push_back('{idle_in(),    o_ce()});
      tbl.push_back('{ov_in(16'h000A), o_ce()});
      tbl.push_back('{idle_in(),    o_tx(8'h0A)});
      tbl.push_back('{idle_in(),    o_tx(8'h00)});
      tbl.push_back('{idle_in(),    zo()});
      tbl.push_back('{rx_in(8'hDD), zo()});
      tbl.push_back('{rx_in(8'h02), o_ae(4'h2)});
      tbl.push_back('{ov_in(16'h5AA5), o_ce()});
      for (int i = 0; i < 5; i++)
         tbl.push_back('{ff_in(), zo()});
      tbl.push_back('{idle_in(),    o_tx(8'hA5)});
      tbl.push_back('{idle_in(),    o_tx(8'h5A)});
      tbl.push_back('{idle_in(),    zo()});
      tbl.push_back('{rx_in(8'h12), zo()});
      tbl.push_back('{rx_in(8'hAA), zo()});
      tbl.push_back('{rx_in(8'hFF), zo()});
      tbl.push_back('{rx_in(8'hFF), o_we(4'hF, 8'hFF)});
      tbl.push_back('{rx_in(8'hDD), zo()});
      tbl.push_back('{rx_in(8'hF7), o_ae(4'h7)});
      tbl.push_back('{ov_in(16'h8001), o_ce()});
      tbl.push_back('{idle_in(),    o_tx(8'h01)});
      tbl.push_back('{idle_in(),    o_tx(8'h80)});
      tbl.push_back('{idle_in(),    zo()});

      foreach (tbl[i])
         cyc($sformatf("table_row%0d", i), tbl[i].i, tbl[i].o);

      // Read watchdog: seven silent cycles, then the next frame must run
      cyc("wd_rd_op",   rx_in(8'hBB), zo());
      cyc("wd_rd_addr", rx_in(8'h02), o_re(4'h2));
      for (int j = 0; j < 7; j++)
         cyc($sformatf("wd_rd_wait%0d", j), idle_in(), zo());
      cyc("wd_after_aa",   rx_in(8'hAA), zo());
      cyc("wd_after_addr", rx_in(8'h03), zo());
      cyc("wd_after_data", rx_in(8'h44), o_we(4'h3, 8'h44));

      // Response in the last tolerated cycle is still accepted
      cyc("wd_late_op",   rx_in(8'hBB), zo());
      cyc("wd_late_addr", rx_in(8'h09), o_re(4'h9));
      for (int j = 0; j < 6; j++)
         cyc($sformatf("wd_late_wait%0d", j), idle_in(), zo());
      cyc("wd_late_resp", rd_in(8'h77), zo());
      cyc("wd_late_tx",   idle_in(), o_tx(8'h77));
      cyc("wd_late_done", idle_in(), zo());

      // ALU watchdog: a result one cycle too late is ignored
      cyc("wd_alu_op", rx_in(8'hDD), zo());
      cyc("wd_alu_fn", rx_in(8'h05), o_ae(4'h5));
      for (int j = 0; j < 7; j++)
         cyc($sformatf("wd_alu_wait%0d", j), idle_in(), o_ce());
      cyc("wd_alu_stale", ov_in(16'h1234), zo());
      cyc("wd_alu_notx0", idle_in(), zo());
      cyc("wd_alu_notx1", idle_in(), zo());

      // Reset in WR_DATA with the data byte present
      cyc("rst_wr_op",   rx_in(8'hAA), zo());
      cyc("rst_wr_addr", rx_in(8'h05), zo());
      RST = 1'b0;
      cyc("rst_wr_data", rx_in(8'h3C), zo());
      RST = 1'b1;
      cyc("rst_wr_idle", rx_in(8'h3C), zo());
      cyc("rst_wr_quiet", idle_in(), zo());

      // Reset while a TX byte is stalled on a full FIFO
      cyc("rst_tx_op",  rx_in(8'hDD), zo());
      cyc("rst_tx_fn",  rx_in(8'h01), o_ae(4'h1));
      cyc("rst_tx_res", mk_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 16'hABCD, 1'b1), o_ce());
      cyc("rst_tx_full", mk_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1), zo());
      RST = 1'b0;
      cyc("rst_tx_hit", idle_in(), zo());
      RST = 1'b1;
      cyc("rst_tx_after0", idle_in(), zo());
      cyc("rst_tx_after1", idle_in(), zo());

      // Random frames against the transaction-level expectation
      for (int n = 0; n < 200; n++) begin
         int          kind;
         int          k;
         logic [7:0]  a, b, f;
         logic [15:0] val;
         obs_q.delete();
         exp_q.delete();
         kind = $urandom_range(0, 4);
         a    = 8'($urandom);
         b    = 8'($urandom);
         f    = 8'($urandom);
         val  = 16'($urandom);
         k    = $urandom_range(0, 9);
         case (kind)
            0: begin
               send_byte(8'hAA); send_byte(a); send_byte(b);
               exp_q.push_back(ev_w(a[3:0], b));
            end
            1: begin
               send_byte(8'hBB); send_byte(a);
               exp_q.push_back(ev_r(a[3:0]));
               wait_resp(k, 1'b0, val);
               if (k < 7) exp_q.push_back(ev_t(val[7:0]));
            end
            2: begin
               send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(f);
               exp_q.push_back(ev_w(4'h0, a));
               exp_q.push_back(ev_w(4'h1, b));
               exp_q.push_back(ev_a(f[3:0]));
               wait_resp(k, 1'b1, val);
               if (k < 7) begin
                  exp_q.push_back(ev_t(val[7:0]));
                  exp_q.push_back(ev_t(val[15:8]));
               end
            end
            3: begin
               send_byte(8'hDD); send_byte(f);
               exp_q.push_back(ev_a(f[3:0]));
               wait_resp(k, 1'b1, val);
               if (k < 7) begin
                  exp_q.push_back(ev_t(val[7:0]));
                  exp_q.push_back(ev_t(val[15:8]));
               end
            end
            default: begin
               if (a == 8'hAA || a == 8'hBB || a == 8'hCC || a == 8'hDD)
                  a = a ^ 8'h01;
               send_byte(a);
            end
         endcase
         drain();
         compare_frame(n, kind);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
